// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling constants.
// The transmitter imports the same package.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_SAMPLE = 7;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx pad.
// Both stages reset to 1 so that reset does not look like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= rx;
      sync_q <= meta_q;
    end
  end

  assign rx_s = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver with a valid/ready holding register.
// Frames are start, DBIT data bits LSB first, optional parity, stop.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DBIT       = 8,
  parameter int unsigned SB_TICK    = 16,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic            frame_err,
  output logic            parity_err,
  output logic            overrun,
  output logic            busy
);

  localparam int unsigned SW = $clog2(SB_TICK);

  logic rx_s;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .rx_s (rx_s)
  );

  uart_state_e     state_q, state_d;
  logic [3:0]      s_cnt_q, s_cnt_d;
  logic [3:0]      n_q, n_d;
  logic [SW-1:0]   stop_cnt_q, stop_cnt_d;
  logic [DBIT-1:0] shreg_q, shreg_d;
  logic            par_bad_q, par_bad_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            dout_valid_q, dout_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            parity_err_q, parity_err_d;
  logic            overrun_q, overrun_d;
  logic            commit;
  logic            handshake;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      s_cnt_q      <= '0;
      n_q          <= '0;
      stop_cnt_q   <= '0;
      shreg_q      <= '0;
      par_bad_q    <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_cnt_q      <= s_cnt_d;
      n_q          <= n_d;
      stop_cnt_q   <= stop_cnt_d;
      shreg_q      <= shreg_d;
      par_bad_q    <= par_bad_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    s_cnt_d      = s_cnt_q;
    n_d          = n_q;
    stop_cnt_d   = stop_cnt_q;
    shreg_d      = shreg_q;
    par_bad_d    = par_bad_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    overrun_d    = 1'b0;
    commit       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!rx_s) begin
          state_d = StStart;
          s_cnt_d = '0;
        end
      end
      StStart: begin
        if (s_tick) begin
          if (s_cnt_q == 4'(MID_SAMPLE)) begin
            // A high line at mid start bit is a glitch: drop back silently
            if (!rx_s) begin
              state_d   = StData;
              s_cnt_d   = '0;
              n_d       = '0;
              par_bad_d = 1'b0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end
      StData: begin
        if (s_tick) begin
          if (s_cnt_q == 4'(OVERSAMPLE - 1)) begin
            shreg_d = {rx_s, shreg_q[DBIT-1:1]};
            s_cnt_d = '0;
            if (n_q == 4'(DBIT - 1)) begin
              state_d    = (PARITY_EN != 0) ? StParity : StStop;
              stop_cnt_d = '0;
            end else begin
              n_d = n_q + 4'd1;
            end
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end
      StParity: begin
        if (s_tick) begin
          if (s_cnt_q == 4'(OVERSAMPLE - 1)) begin
            par_bad_d  = rx_s ^ (^shreg_q) ^ 1'(PARITY_ODD);
            s_cnt_d    = '0;
            stop_cnt_d = '0;
            state_d    = StStop;
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end
      StStop: begin
        // Leave at the stop sample point so a following start bit is not missed
        if (s_tick) begin
          if (stop_cnt_q == SW'(SB_TICK - 1)) begin
            commit  = 1'b1;
            state_d = StIdle;
          end else begin
            stop_cnt_d = stop_cnt_q + SW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    handshake = dout_valid_q && dout_ready;
    if (commit) begin
      if (!dout_valid_q || handshake) begin
        dout_d       = shreg_q;
        frame_err_d  = !rx_s;
        parity_err_d = par_bad_q;
        dout_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (handshake) begin
      dout_valid_d = 1'b0;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a default instance and a parity-enabled instance driven
// by bit-level frame stimulus, checked against tables and a frame-level model.
module tb_uart_rx;

  logic clk = 1'b0;
  always #10ns clk = ~clk;

  logic       rst;
  logic [1:0] tick_ctr = '0;
  logic       s_tick;
  always @(posedge clk) tick_ctr <= tick_ctr + 2'd1;
  assign s_tick = (tick_ctr == 2'd3);

  logic       rx, dout_ready;
  logic [7:0] dout;
  logic       dout_valid, frame_err, parity_err, overrun, busy;

  logic       rx_p, ready_p;
  logic [7:0] dout_p;
  logic       dout_valid_p, frame_err_p, parity_err_p, overrun_p, busy_p;

  uart_rx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_tick     (s_tick),
    .rx         (rx),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  uart_rx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .clk        (clk),
    .rst        (rst),
    .s_tick     (s_tick),
    .rx         (rx_p),
    .dout       (dout_p),
    .dout_valid (dout_valid_p),
    .dout_ready (ready_p),
    .frame_err  (frame_err_p),
    .parity_err (parity_err_p),
    .overrun    (overrun_p),
    .busy       (busy_p)
  );

  int checks = 0;
  int errors = 0;

  // Accepted frames as {parity_err, frame_err, dout}
  logic [9:0] cap_q[$];
  logic [9:0] capp_q[$];
  int ovr_cnt = 0;
  int ovr_cnt_p = 0;

  always @(negedge clk) begin
    if (dout_valid && dout_ready) cap_q.push_back({parity_err, frame_err, dout});
    if (dout_valid_p && ready_p) capp_q.push_back({parity_err_p, frame_err_p, dout_p});
    if (overrun) ovr_cnt <= ovr_cnt + 1;
    if (overrun_p) ovr_cnt_p <= ovr_cnt_p + 1;
  end

  task automatic wait_clk(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1ns;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic set_line(input bit sel, input logic v);
    if (sel) rx_p = v;
    else rx = v;
  endtask

  // 64 clks per bit; a low stop bit is held only 48 clks so its tail is a short glitch
  task automatic send_frame(input bit sel, input logic [7:0] data, input logic par_bit,
                            input logic stop_bit, input int rst_bit);
    set_line(sel, 1'b0);
    wait_clk(64);
    for (int i = 0; i < 8; i++) begin
      set_line(sel, data[i]);
      if (i == rst_bit) begin
        wait_clk(32);
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        check("rst_mid_dout", {24'd0, dout}, 32'd0);
        check("rst_mid_valid", {31'd0, dout_valid}, 32'd0);
        check("rst_mid_flags", {29'd0, frame_err, parity_err, overrun}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        wait_clk(31);
      end else begin
        wait_clk(64);
      end
    end
    if (sel) begin
      set_line(sel, par_bit);
      wait_clk(64);
    end
    set_line(sel, stop_bit);
    if (stop_bit) begin
      wait_clk(64);
    end else begin
      wait_clk(48);
      set_line(sel, 1'b1);
      wait_clk(16);
    end
    set_line(sel, 1'b1);
  endtask

  task automatic expect_cap(input bit sel, input string name, input logic [9:0] exp);
    int t;
    logic [9:0] got;
    t = 0;
    while (((sel ? capp_q.size() : cap_q.size()) == 0) && t < 2000) begin
      wait_clk(1);
      t++;
    end
    if ((sel ? capp_q.size() : cap_q.size()) == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: actual no frame within 2000 clks, required %0h", name, exp);
    end else begin
      got = sel ? capp_q.pop_front() : cap_q.pop_front();
      check(name, {22'd0, got}, {22'd0, exp});
    end
  endtask

  // Frame-level reference: what the host must see for a frame on the wire
  function automatic logic [9:0] model(input bit sel, input logic [7:0] data,
                                       input logic par_bit, input logic stop_bit);
    int ones;
    logic perr;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(data[i]);
    perr = sel ? 1'(((ones + int'(par_bit)) % 2) != 0) : 1'b0;
    return {perr, ~stop_bit, data};
  endfunction

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    logic [7:0] exp_dout;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[6];
  logic prev_busy;
  int   tw;
  int   ovr_base;
  logic busy_seen;

  initial begin
    #5ms;
    $display("FAIL watchdog: actual time limit reached, required finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'h55, 1'b1, 8'h55, 1'b0};
    vecs[1] = '{8'hC4, 1'b0, 8'hC4, 1'b1};
    vecs[2] = '{8'h01, 1'b1, 8'h01, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 8'h00, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, 8'hFF, 1'b1};
    vecs[5] = '{8'h80, 1'b1, 8'h80, 1'b0};

    rx = 1'b1;
    rx_p = 1'b1;
    dout_ready = 1'b1;
    ready_p = 1'b1;
    rst = 1'b1;
    wait_clk(4);
    check("reset_dout", {24'd0, dout}, 32'd0);
    check("reset_valid", {31'd0, dout_valid}, 32'd0);
    check("reset_flags", {29'd0, frame_err, parity_err, overrun}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    wait_clk(10);

    // 0x55 with immediate acceptance; busy drops on the commit edge
    prev_busy = 1'b0;
    tw = 0;
    fork
      send_frame(1'b0, 8'h55, 1'b0, 1'b1, -1);
      begin
        while (!dout_valid && tw < 1000) begin
          prev_busy = busy;
          wait_clk(1);
          tw++;
        end
        check("t1_valid_seen", {31'd0, dout_valid}, 32'd1);
        check("t1_busy_before_commit", {31'd0, prev_busy}, 32'd1);
        check("t1_busy_at_commit", {31'd0, busy}, 32'd0);
        check("t1_dout", {24'd0, dout}, 32'h55);
        check("t1_ferr", {31'd0, frame_err}, 32'd0);
        wait_clk(1);
        check("t1_valid_one_clk", {31'd0, dout_valid}, 32'd0);
      end
    join
    expect_cap(1'b0, "t1_capture", 10'h055);
    wait_clk(64);

    // Back-to-back with host stalled: second frame overruns
    dout_ready = 1'b0;
    ovr_base = ovr_cnt;
    send_frame(1'b0, 8'hA3, 1'b0, 1'b1, -1);
    check("t2_first_valid", {31'd0, dout_valid}, 32'd1);
    check("t2_first_dout", {24'd0, dout}, 32'hA3);
    send_frame(1'b0, 8'h0F, 1'b0, 1'b1, -1);
    wait_clk(8);
    check("t2_overrun_pulses", ovr_cnt - ovr_base, 32'd1);
    check("t2_dout_held", {24'd0, dout}, 32'hA3);
    check("t2_valid_held", {31'd0, dout_valid}, 32'd1);
    check("t2_no_capture", cap_q.size(), 32'd0);
    dout_ready = 1'b1;
    wait_clk(2);
    expect_cap(1'b0, "t2_capture", 10'h0A3);
    check("t2_valid_cleared", {31'd0, dout_valid}, 32'd0);
    wait_clk(64);

    // Short low glitch aborts at the mid start sample
    busy_seen = 1'b0;
    rx = 1'b0;
    for (int i = 0; i < 12; i++) begin
      wait_clk(1);
      busy_seen = busy_seen | busy;
    end
    rx = 1'b1;
    tw = 0;
    while (busy && tw < 200) begin
      wait_clk(1);
      tw++;
    end
    check("t3_busy_seen", {31'd0, busy_seen}, 32'd1);
    check("t3_busy_idle", {31'd0, busy}, 32'd0);
    wait_clk(64);
    check("t3_no_frame", cap_q.size(), 32'd0);
    check("t3_no_valid", {31'd0, dout_valid}, 32'd0);

    // Table: clean and broken stop bits
    for (int i = 0; i < 6; i++) begin
      send_frame(1'b0, vecs[i].data, 1'b0, vecs[i].stop_bit, -1);
      wait_clk(128);
      expect_cap(1'b0, $sformatf("tbl%0d", i), {1'b0, vecs[i].exp_ferr, vecs[i].exp_dout});
    end

    // Even parity on the parity instance
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, -1);
    wait_clk(128);
    expect_cap(1'b1, "t5_parity_good", 10'h007);
    send_frame(1'b1, 8'h07, 1'b0, 1'b1, -1);
    wait_clk(128);
    expect_cap(1'b1, "t5_parity_bad", 10'h207);

    // Reset during data bit 4 of 0xFF, then a clean 0x3C
    send_frame(1'b0, 8'hFF, 1'b0, 1'b1, 4);
    wait_clk(128);
    check("t6_no_frame", cap_q.size(), 32'd0);
    check("t6_idle", {31'd0, busy}, 32'd0);
    send_frame(1'b0, 8'h3C, 1'b0, 1'b1, -1);
    wait_clk(64);
    expect_cap(1'b0, "t6_after_reset", 10'h03C);

    // Random frames against the model
    ovr_base = ovr_cnt;
    for (int i = 0; i < 24; i++) begin
      bit         sel;
      logic [7:0] d;
      logic       p, s;
      sel = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      p = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 4) != 0);
      send_frame(sel, d, p, s, -1);
      wait_clk($urandom_range(128, 256));
      expect_cap(sel, $sformatf("rnd%0d", i), model(sel, d, p, s));
    end
    check("rnd_no_overrun", ovr_cnt - ovr_base, 32'd0);
    check("rnd_no_overrun_p", ovr_cnt_p, 32'd0);
    check("rnd_no_extra", cap_q.size() + capp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
